// File: rtl/mac_datapath.sv
// mac_datapath: datapath that answers the MAC control FSM. For each vector
// element it loads one row and one column operand, multiplies them into a
// registered product, then adds the product to the running sum. A done pulse
// publishes the sum. Control sequences that break load -> mult -> acc are
// ignored and raise a sticky protocol_err flag.
module mac_datapath #(
  parameter  int SIZE   = 4,
  parameter  int DATA_W = 8,
  parameter  int ACC_W  = 2*DATA_W + $clog2(SIZE),
  localparam int CNT_W  = $clog2(SIZE) + 1,
  localparam int IDX_W  = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int PROD_W = 2*DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic                     mult_en,
  input  logic                     acc_en,
  input  logic [SIZE-1:0]          memsel,
  input  logic                     done,
  input  logic [SIZE*DATA_W-1:0]   row_data,
  input  logic [SIZE*DATA_W-1:0]   col_data,
  output logic signed [ACC_W-1:0]  result,
  output logic                     result_valid,
  output logic [CNT_W-1:0]         elem_count,
  output logic                     busy,
  output logic                     protocol_err
);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_LOADED = 2'd1,
    PH_MULTED = 2'd2
  } phase_t;

  phase_t phase, phase_next;

  logic signed [DATA_W-1:0] row_elem [SIZE];
  logic signed [DATA_W-1:0] col_elem [SIZE];
  logic signed [DATA_W-1:0] a_reg, b_reg;
  logic signed [PROD_W-1:0] prod_reg;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic [CNT_W-1:0]         cnt, cnt_next;

  logic [IDX_W-1:0] sel_idx;
  logic [1:0]       n_en;
  logic             multi_en, memsel_legal;
  logic             load_ok, mult_ok, acc_ok, first_load;
  logic             en_err, done_err, err_next;

  // Unpack the flattened operand buses into per-element views.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_unpack
    assign row_elem[gi] = row_data[gi*DATA_W +: DATA_W];
    assign col_elem[gi] = col_data[gi*DATA_W +: DATA_W];
  end

  // Element index is the position of the highest set memsel bit.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (memsel[i]) sel_idx = IDX_W'(i);
    end
  end

  // Qualify each enable against the current phase and flag violations.
  always_comb begin
    n_en         = {1'b0, load_en} + {1'b0, mult_en} + {1'b0, acc_en};
    multi_en     = (n_en > 2'd1);
    memsel_legal = (memsel != '0) && ((memsel & (memsel + SIZE'(1))) == '0);
    load_ok      = load_en && !multi_en && (phase == PH_IDLE) && memsel_legal;
    mult_ok      = mult_en && !multi_en && (phase == PH_LOADED);
    acc_ok       = acc_en  && !multi_en && (phase == PH_MULTED);
    first_load   = load_ok && (memsel == SIZE'(1));
    en_err       = (load_en || mult_en || acc_en) && !(load_ok || mult_ok || acc_ok);
    // A done that lands on a valid final accumulation is the normal end of
    // an element, not a truncated one.
    done_err     = done && (phase != PH_IDLE) && !acc_ok;
    err_next     = first_load ? 1'b0 : (protocol_err || en_err || done_err);
  end

  // Next phase: each accepted step advances, done always returns to idle.
  always_comb begin
    phase_next = phase;
    if (load_ok)      phase_next = PH_LOADED;
    else if (mult_ok) phase_next = PH_MULTED;
    else if (acc_ok)  phase_next = PH_IDLE;
    if (done)         phase_next = PH_IDLE;
  end

  // Phase register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase <= PH_IDLE;
    else        phase <= phase_next;
  end

  // Running sum and element count, including a same-cycle accumulation so
  // that a done coincident with the last acc_en publishes the full sum.
  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    if (first_load) begin
      acc_next = '0;
      cnt_next = '0;
    end else if (acc_ok) begin
      acc_next = acc + ACC_W'(prod_reg);
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // Datapath registers, publish logic and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg        <= '0;
      b_reg        <= '0;
      prod_reg     <= '0;
      acc          <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      elem_count   <= '0;
      busy         <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (load_ok) begin
        a_reg <= row_elem[sel_idx];
        b_reg <= col_elem[sel_idx];
      end
      if (mult_ok) prod_reg <= PROD_W'(a_reg) * PROD_W'(b_reg);
      acc          <= acc_next;
      cnt          <= cnt_next;
      result_valid <= done;
      if (done) begin
        result     <= acc_next;
        elem_count <= cnt_next;
      end
      if (done)            busy <= 1'b0;
      else if (first_load) busy <= 1'b1;
      protocol_err <= err_next;
    end
  end

endmodule

// File: tb/tb_mac_datapath.sv
// Bench for mac_datapath: drives load/mult/acc sequences with random operands
// and gaps, predicts each published dot product from the operand vectors, and
// a separate monitor compares every result_valid pulse against the queue.
module tb_mac_datapath;
  localparam int SIZE   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_en = 1'b0, mult_en = 1'b0, acc_en = 1'b0, done = 1'b0;
  logic [SIZE-1:0] memsel = '0;
  logic [SIZE*DATA_W-1:0] row_data = '0, col_data = '0;
  logic signed [ACC_W-1:0] result;
  logic result_valid;
  logic [CNT_W-1:0] elem_count;
  logic busy, protocol_err;

  always #5 clk = ~clk;

  mac_datapath #(.SIZE(SIZE), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .mult_en(mult_en),
    .acc_en(acc_en), .memsel(memsel), .done(done), .row_data(row_data),
    .col_data(col_data), .result(result), .result_valid(result_valid),
    .elem_count(elem_count), .busy(busy), .protocol_err(protocol_err)
  );

  typedef struct { int res; int cnt; bit err; } exp_t;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int row_v[SIZE];
  int col_v[SIZE];
  int exp_sum = 0;
  int exp_cnt = 0;
  bit exp_err = 0;

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [SIZE-1:0] thermo(int i);
    return SIZE'((1 << (i + 1)) - 1);
  endfunction

  task automatic set_vectors();
    for (int i = 0; i < SIZE; i++) begin
      row_data[i*DATA_W +: DATA_W] = DATA_W'(row_v[i]);
      col_data[i*DATA_W +: DATA_W] = DATA_W'(col_v[i]);
    end
  endtask

  task automatic rand_vectors();
    for (int i = 0; i < SIZE; i++) begin
      row_v[i] = int'($urandom_range(0, 255)) - 128;
      col_v[i] = int'($urandom_range(0, 255)) - 128;
    end
    set_vectors();
  endtask

  // One clock of control stimulus, then all enables drop back to zero.
  task automatic cycle(bit l, bit m, bit a, bit d, logic [SIZE-1:0] ms);
    load_en = l; mult_en = m; acc_en = a; done = d; memsel = ms;
    @(posedge clk); #1;
    load_en = 0; mult_en = 0; acc_en = 0; done = 0; memsel = '0;
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_exp();
    exp_t e;
    e.res = exp_sum; e.cnt = exp_cnt; e.err = exp_err;
    exp_q.push_back(e);
  endtask

  // Legal load -> mult -> acc for element i; optionally done with the acc.
  task automatic elem(int i, bit done_on_acc);
    cycle(1, 0, 0, 0, thermo(i));
    if (i == 0) begin exp_sum = 0; exp_cnt = 0; exp_err = 0; end
    gap(); cycle(0, 1, 0, 0, '0);
    gap(); cycle(0, 0, 1, done_on_acc, '0);
    exp_sum += row_v[i] * col_v[i];
    exp_cnt++;
    if (done_on_acc) push_exp();
  endtask

  task automatic publish();
    cycle(0, 0, 0, 1, '0);
    push_exp();
  endtask

  task automatic run_op(int k);
    for (int i = 0; i < k; i++) elem(i, 1'b0);
    gap();
    publish();
  endtask

  // Monitor: every publish must match the oldest outstanding prediction.
  always @(negedge clk) begin
    exp_t e;
    if (reset && result_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got result %0d, expected no publish", result);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("elem_count", elem_count, e.cnt);
        check("protocol_err_at_publish", protocol_err, e.err);
        check("busy_after_publish", busy, 0);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_count", elem_count, 0);
    check("rst_busy", busy, 0);
    check("rst_err", protocol_err, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic dot product 1..4 . 5..8 = 70, with busy visible mid-operation
    row_v = '{1, 2, 3, 4}; col_v = '{5, 6, 7, 8}; set_vectors();
    elem(0, 1'b0);
    check("busy_mid_op", busy, 1);
    for (int i = 1; i < SIZE; i++) elem(i, 1'b0);
    publish();

    // Extreme operands, then a negative result
    row_v = '{-128, -128, 127, -1}; col_v = '{-128, -128, 127, 1}; set_vectors();
    run_op(4);
    row_v = '{-128, 0, 0, 0}; col_v = '{127, 0, 0, 0}; set_vectors();
    run_op(4);

    // Back-to-back random operations of random length
    for (int n = 0; n < 20; n++) begin
      rand_vectors();
      run_op($urandom_range(1, SIZE));
    end

    // Protocol violations are ignored but flagged
    row_v = '{3, -5, 7, 9}; col_v = '{2, 4, -6, 8}; set_vectors();
    elem(0, 1'b0);
    check("err_clean", protocol_err, 0);
    cycle(0, 1, 0, 0, '0);                 // mult in idle
    exp_err = 1;
    check("err_mult_idle", protocol_err, 1);
    cycle(1, 0, 0, 0, 4'b0101);            // non-thermometer select
    cycle(1, 0, 0, 0, thermo(1));          // must still be accepted
    cycle(0, 0, 1, 0, '0);                 // acc while only loaded
    cycle(1, 1, 0, 0, thermo(1));          // two enables at once
    cycle(0, 1, 0, 0, '0);
    cycle(0, 0, 1, 0, '0);
    exp_sum += row_v[1] * col_v[1]; exp_cnt++;
    elem(2, 1'b0);
    elem(3, 1'b0);
    publish();
    rand_vectors();
    elem(0, 1'b0);
    check("err_cleared_by_first_load", protocol_err, 0);
    for (int i = 1; i < SIZE; i++) elem(i, 1'b0);
    publish();

    // done coincident with the final accumulation
    row_v = '{1, 1, 1, 1}; col_v = '{2, 2, 2, 2}; set_vectors();
    for (int i = 0; i < SIZE; i++) elem(i, i == SIZE - 1);

    // Asynchronous reset between mult and acc of element 2
    rand_vectors();
    elem(0, 1'b0);
    cycle(1, 0, 0, 0, thermo(1));
    cycle(0, 1, 0, 0, '0);
    #2 reset = 1'b0;
    #1;
    check("midrst_result", result, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_count", elem_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", protocol_err, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    rand_vectors();
    run_op(4);

    // Drain outstanding predictions
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
